pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Pipeline control block that consumes the RAW-hazard `stall` request and the EX-stage branch redirect, and acts on them. It owns the IF/ID pipeline register, gates the PC write, and tells the ID/EX register when to load a bubble. It also tracks stall and flush events in saturating counters, and flags any stall that lasts longer than the pipeline depth allows. It sits between fetch, the hazard detector and the ID/EX register.

## Interface
- `XLEN`, 32: PC and instruction width.
- `MAX_STALL`, 3: longest legal run of consecutive honored stall cycles. A 5-stage pipeline with WB-to-ID dependency gives at most 3.
- `CNT_W`, 16: width of the performance counters.
- `NOP_INSTR`, 32'h00000013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard request from the hazard detector (combinational, same cycle).
- `branch_taken_ex`  in  1  EX-stage taken branch or jump.
- `if_pc`  in  XLEN  PC of the instruction currently in IF.
- `if_instr`  in  XLEN  instruction currently in IF.
- `if_valid`  in  1  IF holds a real instruction.
- `pc_we`  out  1  PC register write enable.
- `pc_sel`  out  1  1 selects the branch target, 0 selects PC+4.
- `id_pc`  out  XLEN  registered IF/ID PC.
- `id_instr`  out  XLEN  registered IF/ID instruction.
- `id_valid`  out  1  registered IF/ID valid.
- `ex_bubble`  out  1  ID/EX loads `NOP_INSTR` with valid=0 this edge.
- `stall_cnt`  out  CNT_W  honored stall cycles, saturating.
- `flush_cnt`  out  CNT_W  branch redirects, saturating.
- `stall_err`  out  1  sticky; set on a stall run longer than `MAX_STALL`.

## Operation
- States are RUN, STALL and FLUSH, held in a 2-bit register.
- `stall_hon = stall & id_valid & ~branch_taken_ex`. A stall request against an empty ID slot is ignored.
- Priority from highest to lowest: reset, then `branch_taken_ex`, then `stall_hon`, then normal advance.

Per-cycle behaviour:
- **Branch cycle** (`branch_taken_ex=1`, any state):
  - `pc_sel=1`, `pc_we=1`, `ex_bubble=1`.
  - IF/ID loads `id_valid=0`, `id_instr=NOP_INSTR`, `id_pc=if_pc`.
  - `flush_cnt` increments.
  - Next state is FLUSH; the stall run counter clears.
- **Stall cycle** (`stall_hon=1`):
  - `pc_we=0`, `pc_sel=0`, `ex_bubble=1`.
  - IF/ID holds its value.
  - `stall_cnt` increments and the run counter increments.
  - Next state is STALL.
- **Advance cycle** (neither condition):
  - `pc_we=1`, `pc_sel=0`, `ex_bubble = ~id_valid`.
  - IF/ID loads `if_pc`, `if_instr` and `if_valid`. When `if_valid=0`, `id_instr` loads `NOP_INSTR`.
  - The run counter clears and the next state is RUN.
- **FLUSH state**: lasts exactly one cycle and behaves as an advance cycle. `id_valid=0` there, so stall is never honored in FLUSH. A branch in FLUSH is legal and re-enters FLUSH.
- **Stall overflow**: the run counter is `$clog2(MAX_STALL+2)` bits wide and saturates.
  - `stall_err` sets on the edge where a stall is honored with the run counter already equal to `MAX_STALL`.
  - `stall_err` clears only on reset.
  - The stall continues to be honored after the error; the block never breaks a stall on its own.
- **Counters**: `stall_cnt` and `flush_cnt` hold at all-ones rather than wrapping.

## Timing
- `pc_we`, `pc_sel` and `ex_bubble` are combinational from `stall`, `branch_taken_ex` and `id_valid`, with no added latency.
- All other outputs are registered and change one edge after the deciding cycle.
- Reset values, applied immediately and asynchronously while `rst_n=0`:
  - `id_pc=0`, `id_instr=NOP_INSTR`, `id_valid=0`.
  - `stall_cnt=0`, `flush_cnt=0`, `stall_err=0`.
  - State RUN, run counter 0.
  - With `id_valid=0`, the combinational outputs are `pc_we=1`, `pc_sel=0`, `ex_bubble=1`.
- Reset released mid-stall or mid-flush restarts in RUN with an empty ID slot; no stale instruction survives.
- When `stall` and `branch_taken_ex` assert in the same cycle, the branch wins. The stalled instruction is squashed and `stall_cnt` does not increment.
- The first instruction reaches ID one edge after it is presented in IF with `pc_we=1`.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs → `id_valid=0`, `id_instr=0x00000013`, counters 0, `stall_err=0`, `pc_we=1`. Release with `if_pc=0x100`, `if_valid=1` → next edge `id_pc=0x100`, `id_valid=1`.
- **Single stall:** ID holds `pc=0x104`; assert `stall` for 1 cycle → that cycle `pc_we=0`, `ex_bubble=1`. `id_pc` stays 0x104 across the edge and `stall_cnt=1`. Next cycle ID advances to 0x108.
- **Max stall:** 3 consecutive cycles with `stall=1` → `stall_cnt=3`, `stall_err=0`. A 4th consecutive cycle → `stall_err=1` after the edge, remaining set after `stall` drops.
- **Branch vs stall:** `stall=1` and `branch_taken_ex=1` together → `pc_sel=1`, `pc_we=1`, `ex_bubble=1`, `stall_cnt` unchanged, `flush_cnt=1`, next `id_valid=0`. Holding `stall=1` the following cycle (FLUSH) → `pc_we=1`, no stall counted.
- **Back-to-back branches:** `branch_taken_ex=1` on two consecutive cycles → `flush_cnt=2`, `id_valid=0` for both following edges, state FLUSH both times.
- **Saturation:** force `CNT_W=4`, then 20 separated single stalls → `stall_cnt` holds at 15.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Owns the IF/ID pipeline register and arbitrates the RAW-hazard stall
// request against the EX-stage branch redirect. It gates the PC write,
// selects the branch target, and tells the ID/EX register when to load a
// bubble. It also keeps saturating stall/flush event counters and a sticky
// flag for stall runs longer than the pipeline allows.
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   stall            hazard request (combinational, same cycle)
//   branch_taken_ex  EX-stage taken branch / jump
//   if_pc, if_instr  PC and instruction currently in IF
//   if_valid         IF holds a real instruction
//   pc_we            PC register write enable        (combinational)
//   pc_sel           1 = branch target, 0 = PC+4      (combinational)
//   ex_bubble        ID/EX loads a NOP with valid=0   (combinational)
//   id_pc, id_instr, id_valid   registered IF/ID contents
//   stall_cnt        honored stall cycles, saturating
//   flush_cnt        branch redirects, saturating
//   stall_err        sticky, stall run exceeded MAX_STALL
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int              XLEN      = 32,
    parameter int              MAX_STALL = 3,
    parameter int              CNT_W     = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken_ex,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_instr,
    input  logic             if_valid,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_instr,
    output logic             id_valid,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    localparam int               RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic             stall_hon;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (&v) ? v : v + RUN_W'(1);
    endfunction

    // A stall against an empty ID slot has nothing to protect, and a branch
    // squashes the stalled instruction anyway. FLUSH always has an empty ID
    // slot; the explicit state term keeps that guarantee independent of it.
    assign stall_hon = stall & id_valid & ~branch_taken_ex & (state != ST_FLUSH);

    assign pc_we     = branch_taken_ex | ~stall_hon;
    assign pc_sel    = branch_taken_ex;
    assign ex_bubble = branch_taken_ex | stall_hon | ~id_valid;

    // IF -> ID boundary: IF/ID register, state, run counter and event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            run_cnt   <= '0;
            id_pc     <= '0;
            id_instr  <= NOP_INSTR;
            id_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            stall_err <= 1'b0;
        end else if (branch_taken_ex) begin
            state     <= ST_FLUSH;
            run_cnt   <= '0;
            id_pc     <= if_pc;
            id_instr  <= NOP_INSTR;
            id_valid  <= 1'b0;
            flush_cnt <= sat_inc_cnt(flush_cnt);
        end else if (stall_hon) begin
            // IF/ID holds; the stall is never broken here, only reported.
            state     <= ST_STALL;
            run_cnt   <= sat_inc_run(run_cnt);
            stall_cnt <= sat_inc_cnt(stall_cnt);
            if (run_cnt == RUN_LIMIT) begin
                stall_err <= 1'b1;
            end
        end else begin
            state     <= ST_RUN;
            run_cnt   <= '0;
            id_pc     <= if_pc;
            id_instr  <= if_valid ? if_instr : NOP_INSTR;
            id_valid  <= if_valid;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        s;
        logic        br;
        logic [31:0] pc;
        logic        v;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        err;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken_ex;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    logic        pc_we, pc_sel, ex_bubble, id_valid, stall_err;
    logic [31:0] id_pc, id_instr;
    logic [15:0] stall_cnt, flush_cnt;

    logic        we4, sel4, bub4, valid4, err4;
    logic [31:0] pc4, instr4;
    logic [3:0]  sc4, fc4;

    logic [171:0] obs_vec;
    logic [5:0]   obs_comb;

    exp_t  m;
    int    m_run;
    logic  [2:0] e_comb;
    exp_t  sb_q[$];

    int n_checks;
    int n_fail;

    pipeline_stall_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken_ex(branch_taken_ex),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .pc_we(pc_we), .pc_sel(pc_sel), .id_pc(id_pc), .id_instr(id_instr),
        .id_valid(id_valid), .ex_bubble(ex_bubble), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .stall_err(stall_err)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken_ex(branch_taken_ex),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .pc_we(we4), .pc_sel(sel4), .id_pc(pc4), .id_instr(instr4),
        .id_valid(valid4), .ex_bubble(bub4), .stall_cnt(sc4),
        .flush_cnt(fc4), .stall_err(err4)
    );

    assign obs_vec  = {id_pc, id_instr, id_valid, stall_cnt, flush_cnt, stall_err,
                       pc4, instr4, valid4, sc4, fc4, err4};
    assign obs_comb = {pc_we, pc_sel, ex_bubble, we4, sel4, bub4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[24:0], 7'h33};
    endfunction

    function automatic logic [171:0] exp_vec(input exp_t e);
        return {e.pc, e.instr, e.valid, e.sc, e.fc, e.err,
                e.pc, e.instr, e.valid, e.sc4, e.fc4, e.err};
    endfunction

    task automatic model_reset();
        m       = '0;
        m.instr = NOP;
        m_run   = 0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus at the falling edge, predict the
    // combinational outputs for this cycle and push the registered state
    // expected after the next rising edge.
    task automatic apply(input stim_t t);
        logic hon;
        @(negedge clk);
        stall           = t.s;
        branch_taken_ex = t.br;
        if_pc           = t.pc;
        if_instr        = instr_of(t.pc);
        if_valid        = t.v;
        hon    = t.s & m.valid & ~t.br;
        e_comb = {t.br | ~hon, t.br, t.br | hon | ~m.valid};
        if (!rst_n) begin
            m       = '0;
            m.instr = NOP;
            m_run   = 0;
        end else if (t.br) begin
            m.pc    = t.pc;
            m.instr = NOP;
            m.valid = 1'b0;
            if (m.fc != 16'hFFFF) m.fc = m.fc + 16'd1;
            if (m.fc4 != 4'hF) m.fc4 = m.fc4 + 4'd1;
            m_run = 0;
        end else if (hon) begin
            if (m.sc != 16'hFFFF) m.sc = m.sc + 16'd1;
            if (m.sc4 != 4'hF) m.sc4 = m.sc4 + 4'd1;
            if (m_run == 3) m.err = 1'b1;
            if (m_run < 7) m_run = m_run + 1;
        end else begin
            m.pc    = t.pc;
            m.instr = t.v ? instr_of(t.pc) : NOP;
            m.valid = t.v;
            m_run   = 0;
        end
        sb_q.push_back(m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim_t tbl[$];
        exp_t  e;
        for (int i = 0; i < 3; i++)
            tbl.push_back({1'($urandom), 1'($urandom), 32'($urandom), 1'($urandom)});
        tbl.push_back({1'b0, 1'b0, 32'h100, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL reset comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL reset regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
            if (i < 3) begin
                n_checks++;
                if ({id_valid, id_instr, stall_cnt, flush_cnt, stall_err, pc_we} !==
                    {1'b0, NOP, 16'd0, 16'd0, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL reset values[%0d]: got valid=%b instr=%h sc=%0d fc=%0d err=%b we=%b",
                             i, id_valid, id_instr, stall_cnt, flush_cnt, stall_err, pc_we);
                end
            end
            if (i == 2) rst_n = 1'b1;
            if (i == 3) begin
                n_checks++;
                if ({id_pc, id_valid} !== {32'h100, 1'b1}) begin
                    n_fail++;
                    $display("FAIL reset first_instr: got pc=%h valid=%b want pc=00000100 valid=1",
                             id_pc, id_valid);
                end
            end
        end
    endtask

    task automatic test_single_stall();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back({1'b0, 1'b0, 32'h104, 1'b1});
        tbl.push_back({1'b1, 1'b0, 32'h108, 1'b1});
        tbl.push_back({1'b0, 1'b0, 32'h108, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL single_stall comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            if (i == 1) begin
                n_checks++;
                if ({pc_we, ex_bubble} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL single_stall gate: got we=%b bub=%b want we=0 bub=1", pc_we, ex_bubble);
                end
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL single_stall regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
            if (i == 1) begin
                n_checks++;
                if ({id_pc, stall_cnt} !== {32'h104, 16'd1}) begin
                    n_fail++;
                    $display("FAIL single_stall hold: got pc=%h sc=%0d want pc=00000104 sc=1", id_pc, stall_cnt);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (id_pc !== 32'h108) begin
                    n_fail++;
                    $display("FAIL single_stall advance: got pc=%h want 00000108", id_pc);
                end
            end
        end
    endtask

    task automatic test_max_stall();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back({1'b0, 1'b0, 32'h200, 1'b1});
        for (int k = 0; k < 4; k++) tbl.push_back({1'b1, 1'b0, 32'h204, 1'b1});
        tbl.push_back({1'b0, 1'b0, 32'h204, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL max_stall comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL max_stall regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
            if (i == 3) begin
                n_checks++;
                if ({stall_cnt, stall_err} !== {16'd3, 1'b0}) begin
                    n_fail++;
                    $display("FAIL max_stall legal: got sc=%0d err=%b want sc=3 err=0", stall_cnt, stall_err);
                end
            end
            if (i >= 4) begin
                n_checks++;
                if ({stall_err, err4} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL max_stall err[%0d]: got %b%b want 11", i, stall_err, err4);
                end
            end
        end
    endtask

    task automatic test_branch_vs_stall();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back({1'b0, 1'b0, 32'h400, 1'b1});
        tbl.push_back({1'b1, 1'b1, 32'h500, 1'b1});
        tbl.push_back({1'b1, 1'b0, 32'h504, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL branch_vs_stall comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            if (i == 1) begin
                n_checks++;
                if ({pc_sel, pc_we, ex_bubble} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL branch_vs_stall wins: got sel/we/bub=%b%b%b want 111", pc_sel, pc_we, ex_bubble);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (pc_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL branch_vs_stall flush_we: got %b want 1", pc_we);
                end
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL branch_vs_stall regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
            if (i >= 1) begin
                n_checks++;
                if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) begin
                    n_fail++;
                    $display("FAIL branch_vs_stall cnt[%0d]: got sc=%0d fc=%0d want sc=0 fc=1", i, stall_cnt, flush_cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back({1'b0, 1'b0, 32'h600, 1'b1});
        tbl.push_back({1'b0, 1'b1, 32'h700, 1'b1});
        tbl.push_back({1'b1, 1'b1, 32'h704, 1'b1});
        tbl.push_back({1'b0, 1'b0, 32'h708, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL back_to_back comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL back_to_back regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
            if (i == 1 || i == 2) begin
                n_checks++;
                if ({id_valid, flush_cnt} !== {1'b0, 16'(i)}) begin
                    n_fail++;
                    $display("FAIL back_to_back flush[%0d]: got valid=%b fc=%0d want valid=0 fc=%0d",
                             i, id_valid, flush_cnt, i);
                end
            end
        end
    endtask

    task automatic test_saturation();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            tbl.push_back({1'b0, 1'b0, 32'h800 + 32'(8 * k), 1'b1});
            tbl.push_back({1'b1, 1'b0, 32'h804 + 32'(8 * k), 1'b1});
        end
        for (int k = 0; k < 20; k++) tbl.push_back({1'b0, 1'b1, 32'hA00 + 32'(4 * k), 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            n_checks++;
            if (obs_comb !== {2{e_comb}}) begin
                n_fail++;
                $display("FAIL saturation comb[%0d]: got %b want %b", i, obs_comb, {2{e_comb}});
            end
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL saturation regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
        end
        n_checks++;
        if ({sc4, fc4, stall_cnt, flush_cnt, err4} !== {4'd15, 4'd15, 16'd20, 16'd20, 1'b0}) begin
            n_fail++;
            $display("FAIL saturation final: got sc4=%0d fc4=%0d sc=%0d fc=%0d err4=%b want 15 15 20 20 0",
                     sc4, fc4, stall_cnt, flush_cnt, err4);
        end
    endtask

    task automatic test_async_reset();
        stim_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back({1'b0, 1'b0, 32'h300, 1'b1});
        tbl.push_back({1'b1, 1'b0, 32'h304, 1'b1});
        tbl.push_back({1'b1, 1'b0, 32'h304, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if (obs_vec !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL async_reset regs[%0d]: got %h want %h", i, obs_vec, exp_vec(e));
            end
        end
        // Drop reset between edges while the stall request is still held.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({id_valid, id_instr, stall_cnt, valid4, sc4, pc_we, ex_bubble} !==
            {1'b0, NOP, 16'd0, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset immediate: got valid=%b instr=%h sc=%0d we=%b bub=%b",
                     id_valid, id_instr, stall_cnt, pc_we, ex_bubble);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply({1'b1, 1'b0, 32'h308, 1'b1});
        #1;
        n_checks++;
        if (obs_comb !== {2{e_comb}}) begin
            n_fail++;
            $display("FAIL async_reset restart_comb: got %b want %b", obs_comb, {2{e_comb}});
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs_vec !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL async_reset restart: got %h want %h", obs_vec, exp_vec(e));
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        branch_taken_ex = 1'b0;
        if_pc           = '0;
        if_instr        = '0;
        if_valid        = 1'b0;
        model_reset();

        test_reset();
        test_single_stall();
        test_max_stall();
        test_branch_vs_stall();
        test_back_to_back();
        test_saturation();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
